// File: rtl/cnn_stage_sequencer.sv
// cnn_stage_sequencer: chains NUM_STAGES compute stages through start/done
// handshakes, enforces a per-stage timeout, counts the non-idle cycles of a
// frame and holds the final classification in a valid/ready output register.
module cnn_stage_sequencer #(
  parameter  int unsigned NUM_STAGES = 8,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned CLASS_W    = 4,
  parameter  int unsigned TIMEOUT    = 4096,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [CLASS_W-1:0]    result_index,
  input  logic [DATA_W-1:0]     result_max,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CLASS_W-1:0]    out_index,
  output logic [DATA_W-1:0]     out_max,
  output logic [CNT_W-1:0]      out_cycles,
  output logic                  busy,
  output logic                  err,
  output logic [IDX_W-1:0]      err_stage
);

  localparam int unsigned     TMR_W    = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_S  = IDX_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        stage_q, stage_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [NUM_STAGES-1:0]   start_q, start_d;
  logic                    out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]      out_index_q, out_index_d;
  logic [DATA_W-1:0]       out_max_q, out_max_d;
  logic [CNT_W-1:0]        out_cycles_q, out_cycles_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        err_stage_q, err_stage_d;
  logic                    capture;

  // Next-state, sequencing counters and output-register update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
    state_d      = state_q;
    stage_d      = stage_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    err_stage_d  = err_stage_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_max_d    = out_max_q;
    out_cycles_d = out_cycles_q;
    start_d      = '0;
    capture      = 1'b0;
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    if (abort) begin
      // Abort wins over everything and leaves result and error state alone.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_valid) begin
            stage_d = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          timer_d = '0;
          cnt_d   = cnt_inc;
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d   = cnt_inc;
          timer_d = timer_q + TMR_W'(1);
          if (stage_done[stage_q]) begin
            if (stage_q != LAST_S) begin
              stage_d = stage_q + IDX_W'(1);
              state_d = START;
            end else if (!out_valid_q || out_ready) begin
              capture = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = HOLD;
            end
          end else if (timer_q == TMR_END) begin
            err_d       = 1'b1;
            err_stage_d = stage_q;
            state_d     = IDLE;
          end
        end
        HOLD: begin
          cnt_d = cnt_inc;
          if (out_ready) begin
            capture = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // A capture on the same edge as a consume keeps out_valid high with new data.
      if (capture) begin
        out_valid_d  = 1'b1;
        out_index_d  = result_index;
        out_max_d    = result_max;
        out_cycles_d = cnt_inc;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end

    // Start pulse is registered so it is glitch-free and aligned to the START cycle.
    if (state_d == START) start_d[stage_d] = 1'b1;
  end

  // State and datapath registers; output register is reset so all outputs read 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      timer_q      <= '0;
      cnt_q        <= '0;
      start_q      <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_max_q    <= '0;
      out_cycles_q <= '0;
      err_q        <= 1'b0;
      err_stage_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      stage_q      <= stage_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_max_q    <= out_max_d;
      out_cycles_q <= out_cycles_d;
      err_q        <= err_d;
      err_stage_q  <= err_stage_d;
    end
  end

  assign frame_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign stage_start = start_q;
  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign out_max     = out_max_q;
  assign out_cycles  = out_cycles_q;
  assign err         = err_q;
  assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Directed testbench for cnn_stage_sequencer: nominal frame, back-pressure,
// timeout, abort priority, spurious done and asynchronous reset mid-frame.
module tb_cnn_stage_sequencer;

  localparam int unsigned NS      = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned CW      = 4;
  localparam int unsigned TO      = 16;
  localparam int unsigned CNTW    = 16;

  logic            clk;
  logic            reset_n;
  logic            frame_valid;
  logic            frame_ready;
  logic            abort;
  logic [NS-1:0]   stage_start;
  logic [NS-1:0]   stage_done;
  logic [CW-1:0]   result_index;
  logic [DW-1:0]   result_max;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_index;
  logic [DW-1:0]   out_max;
  logic [CNTW-1:0] out_cycles;
  logic            busy;
  logic            err;
  logic [1:0]      err_stage;

  int n_tests = 0;
  int n_fail  = 0;

  cnn_stage_sequencer #(
    .NUM_STAGES(NS), .DATA_W(DW), .CLASS_W(CW), .TIMEOUT(TO), .CNT_W(CNTW)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .abort(abort), .stage_start(stage_start), .stage_done(stage_done),
    .result_index(result_index), .result_max(result_max), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_max(out_max),
    .out_cycles(out_cycles), .busy(busy), .err(err), .err_stage(err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  // Called in the START cycle of stage s: checks the pulse, then completes
  // the stage with done raised in WAIT cycle number 'waits'.
  task automatic do_stage(input int s, input int waits);
    check($sformatf("stage_start_s%0d", s), 64'(stage_start), 64'(1) << s);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) stage_done[s] = 1'b1;
      tick();
    end
    stage_done = '0;
  endtask

  initial begin
    reset_n      = 1'b0;
    frame_valid  = 1'b0;
    abort        = 1'b0;
    stage_done   = '0;
    result_index = '0;
    result_max   = '0;
    out_ready    = 1'b0;
    #23;
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_out_valid",   64'(out_valid),   64'(0));
    check("rst_stage_start", 64'(stage_start), 64'(0));
    check("rst_err",         64'(err),         64'(0));
    check("rst_out_cycles",  64'(out_cycles),  64'(0));
    check("rst_frame_ready", 64'(frame_ready), 64'(1));
    check("rst_busy",        64'(busy),        64'(0));

    // Nominal: 3 WAIT cycles per stage, 4 stages -> 16 cycles
    out_ready    = 1'b1;
    result_index = 4'd7;
    result_max   = 32'h3F00_0000;
    accept();
    check("nom_busy",        64'(busy),        64'(1));
    check("nom_frame_ready", 64'(frame_ready), 64'(0));
    for (int s = 0; s < 4; s++) do_stage(s, 3);
    check("nom_out_valid",  64'(out_valid),  64'(1));
    check("nom_out_index",  64'(out_index),  64'(7));
    check("nom_out_max",    64'(out_max),    64'(32'h3F00_0000));
    check("nom_out_cycles", 64'(out_cycles), 64'(16));
    check("nom_err",        64'(err),        64'(0));
    check("nom_idle",       64'(frame_ready), 64'(1));
    tick();
    check("nom_consumed",   64'(out_valid),  64'(0));

    // Back-pressure: first result left pending, second frame parks in HOLD
    out_ready    = 1'b0;
    result_index = 4'd3;
    result_max   = 32'hAAAA_5555;
    accept();
    for (int s = 0; s < 4; s++) do_stage(s, 2);
    check("bp_a_valid",  64'(out_valid),  64'(1));
    check("bp_a_cycles", 64'(out_cycles), 64'(12));
    result_index = 4'd9;
    result_max   = 32'h1234_5678;
    accept();
    for (int s = 0; s < 4; s++) do_stage(s, 1);
    check("hold_busy",        64'(busy),        64'(1));
    check("hold_frame_ready", 64'(frame_ready), 64'(0));
    check("hold_out_index",   64'(out_index),   64'(3));
    check("hold_out_max",     64'(out_max),     64'(32'hAAAA_5555));
    check("hold_out_cycles",  64'(out_cycles),  64'(12));
    repeat (4) tick();
    check("hold_still_busy",  64'(busy),        64'(1));
    check("hold_still_index", 64'(out_index),   64'(3));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_b_valid",  64'(out_valid),  64'(1));
    check("bp_b_index",  64'(out_index),  64'(9));
    check("bp_b_max",    64'(out_max),    64'(32'h1234_5678));
    check("bp_b_cycles", 64'(out_cycles), 64'(13));
    check("bp_b_idle",   64'(busy),       64'(0));

    // Timeout on stage 1 after 16 WAIT cycles
    accept();
    do_stage(0, 1);
    check("to_stage_start_s1", 64'(stage_start), 64'(4'b0010));
    tick();
    repeat (15) tick();
    check("to_pre_err",  64'(err),  64'(0));
    check("to_pre_busy", 64'(busy), 64'(1));
    tick();
    check("to_err",       64'(err),         64'(1));
    check("to_err_stage", 64'(err_stage),   64'(1));
    check("to_idle",      64'(busy),        64'(0));
    check("to_no_start",  64'(stage_start), 64'(0));
    check("to_out_valid", 64'(out_valid),   64'(1));
    check("to_out_index", 64'(out_index),   64'(9));

    // Next accept clears err; then abort collides with done in WAIT
    accept();
    check("acc_err_clear",  64'(err),         64'(0));
    check("acc_start_s0",   64'(stage_start), 64'(4'b0001));
    tick();
    abort         = 1'b1;
    stage_done[0] = 1'b1;
    tick();
    abort      = 1'b0;
    stage_done = '0;
    check("ab_idle",       64'(busy),        64'(0));
    check("ab_no_start",   64'(stage_start), 64'(0));
    check("ab_out_valid",  64'(out_valid),   64'(1));
    check("ab_out_index",  64'(out_index),   64'(9));
    check("ab_err_stage",  64'(err_stage),   64'(1));
    repeat (3) tick();
    check("ab_quiet_start", 64'(stage_start), 64'(0));
    check("ab_quiet_busy",  64'(busy),        64'(0));

    // Done on the TIMEOUT-1 WAIT cycle advances without error
    out_ready    = 1'b1;
    result_index = 4'd5;
    result_max   = 32'h0BAD_F00D;
    accept();
    do_stage(0, 16);
    check("edge_err", 64'(err), 64'(0));
    for (int s = 1; s < 4; s++) do_stage(s, 1);
    check("edge_valid",  64'(out_valid),  64'(1));
    check("edge_index",  64'(out_index),  64'(5));
    check("edge_cycles", 64'(out_cycles), 64'(23));
    check("edge_err2",   64'(err),        64'(0));

    // Spurious done: bit 1 during START of stage 1, bit 3 while s=1
    result_index = 4'd11;
    result_max   = 32'h7F7F_FFFF;
    accept();
    do_stage(0, 1);
    check("sp_start_s1", 64'(stage_start), 64'(4'b0010));
    stage_done[1] = 1'b1;
    tick();
    stage_done = 4'b1000;
    check("sp_no_advance", 64'(stage_start), 64'(0));
    check("sp_busy",       64'(busy),        64'(1));
    tick();
    tick();
    check("sp_still_wait", 64'(stage_start), 64'(0));
    stage_done = 4'b0010;
    tick();
    stage_done = '0;
    do_stage(2, 1);
    do_stage(3, 1);
    check("sp_index",  64'(out_index),  64'(11));
    check("sp_cycles", 64'(out_cycles), 64'(10));

    // Reset mid-frame during WAIT of stage 2
    out_ready = 1'b0;
    accept();
    do_stage(0, 1);
    do_stage(1, 1);
    check("rm_start_s2", 64'(stage_start), 64'(4'b0100));
    tick();
    check("rm_busy", 64'(busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_out_valid",   64'(out_valid),   64'(0));
    check("rm_out_index",   64'(out_index),   64'(0));
    check("rm_out_max",     64'(out_max),     64'(0));
    check("rm_out_cycles",  64'(out_cycles),  64'(0));
    check("rm_busy_low",    64'(busy),        64'(0));
    check("rm_stage_start", 64'(stage_start), 64'(0));
    check("rm_err_stage",   64'(err_stage),   64'(0));
    #3;
    reset_n = 1'b1;
    tick();
    check("rm_frame_ready", 64'(frame_ready), 64'(1));
    out_ready    = 1'b1;
    result_index = 4'd2;
    result_max   = 32'h4049_0FDB;
    accept();
    for (int s = 0; s < 4; s++) do_stage(s, 2);
    check("rs_valid",  64'(out_valid),  64'(1));
    check("rs_index",  64'(out_index),  64'(2));
    check("rs_max",    64'(out_max),    64'(32'h4049_0FDB));
    check("rs_cycles", 64'(out_cycles), 64'(12));
    check("rs_err",    64'(err),        64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_stage_sequencer.md
# cnn_stage_sequencer

Parametrised frame sequencer for the CNN datapath. It chains NUM_STAGES compute stages (conv, tanh, pool, FC, softmax) through start/done handshakes with per-stage timeouts, abort and cycle accounting. It replaces hard-wired done-to-start wiring between layer instances. It sits between the frame source and the classifier result consumer, and holds the final class index and score in a valid/ready output register.

## Interface
- NUM_STAGES, 8, number of chained stages (≥1)
- DATA_W, 32, width of the result score word
- CLASS_W, 4, width of the class index
- TIMEOUT, 4096, max WAIT cycles per stage before error (≥2)
- CNT_W, 16, width of frame cycle counter (saturating)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_valid  in  1  new frame available
- frame_ready  out  1  sequencer can accept a frame (= state IDLE)
- abort  in  1  synchronous abort, highest priority
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to stage s
- stage_done  in  NUM_STAGES  done from each stage; only bit s is examined
- result_index  in  CLASS_W  class index from final stage, stable once last done is seen
- result_max  in  DATA_W  max score from final stage, stable with result_index
- out_valid  out  1  output register holds an unconsumed result
- out_ready  in  1  consumer accepts the result
- out_index  out  CLASS_W  captured class index
- out_max  out  DATA_W  captured score
- out_cycles  out  CNT_W  non-IDLE cycles spent on that frame
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag, cleared on the next frame accept
- err_stage  out  $clog2(NUM_STAGES) (min 1)  stage that timed out

## Operation
- States: IDLE, START, WAIT, HOLD. Stage index s and a WAIT timer are kept internally.
- IDLE:
  - Accept when frame_valid && frame_ready; then s=0, err=0, cycle counter=0, go to START.
- START:
  - stage_start[s]=1 for exactly this cycle.
  - Timer is cleared and the counter increments.
  - Go to WAIT.
- WAIT:
  - Counter increments and timer increments.
  - If stage_done[s] and s<NUM_STAGES-1: s++, go to START.
  - If stage_done[s] and s==NUM_STAGES-1: capture if !out_valid || out_ready, then go to IDLE. Otherwise go to HOLD.
  - Else if timer==TIMEOUT-1: err=1, err_stage=s, go to IDLE, no capture.
- HOLD:
  - Counter increments.
  - When out_ready: capture, go to IDLE.
- Capture:
  - out_index←result_index, out_max←result_max, out_cycles←counter+1, out_valid←1.
- out_valid clears on out_ready && out_valid unless a capture occurs the same edge; in that case it stays 1 with the new data.
- Priority: abort > done > timeout.
  - abort in any state → IDLE next edge; stage_start=0; the output register and err are unchanged.
- stage_done bits other than s, and stage_done[s] during START, are ignored.
- The counter saturates at 2^CNT_W-1.
- A new frame may be accepted while out_valid is pending; the result is protected by HOLD.

## Timing
- Reset: state IDLE, all outputs 0. frame_ready is 1 after reset release (combinational from state).
- Accept edge → stage_start[0] high the next cycle.
- Done seen in WAIT → stage_start[s+1] high the next cycle, giving 1 START + ≥1 WAIT cycle per stage.
- Frame latency = Σ(1 + wait_s) cycles from the accept edge to out_valid rising.
- Timeout: err rises after exactly TIMEOUT WAIT cycles on one stage.
- All outputs are registered except frame_ready and busy (decoded from state).
- reset_n deassertion mid-frame clears everything immediately (asynchronous). No stage_start glitches.

## Test plan
- Nominal, NUM_STAGES=2:
  - Stimulus: each done asserted in the 3rd WAIT cycle; result_index=7, result_max=32'h3F000000; out_ready=1.
  - Required: stage_start = 01 then 10, out_valid after 8 cycles, out_index=7, out_max=32'h3F000000, out_cycles=8, err=0.
- Back-pressure:
  - Stimulus: out_ready=0 with the previous result pending when the last done arrives.
  - Required: state HOLD, busy=1, frame_ready=0, out_* unchanged.
  - Stimulus: raise out_ready 5 cycles later.
  - Required: new result captured that edge, out_valid stays 1, out_cycles counts the 5 HOLD cycles.
- Timeout, TIMEOUT=16:
  - Stimulus: stage 1 never completes.
  - Required: err=1, err_stage=1 after 16 WAIT cycles, return to IDLE, out_valid unchanged.
  - Stimulus: next accept.
  - Required: err clears.
- Abort and priority:
  - Stimulus: abort asserted in WAIT on the same cycle as stage_done[s].
  - Required: IDLE next edge, no further stage_start, no capture.
  - Stimulus: done on the TIMEOUT-1 cycle without abort.
  - Required: advances, err=0.
- Spurious done:
  - Stimulus: stage_done[3] while s=1, and stage_done[1] during START.
  - Required: both ignored, sequencing unchanged.
- Reset mid-frame:
  - Stimulus: reset_n low during WAIT of stage 2.
  - Required: all outputs 0 immediately, frame_ready=1 after release, clean restart on the next frame.
